// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO serializer.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PARITY_BITS = 1;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } piso_state_t;

  localparam int PARITY_BITS = 0;
`endif

  // Serial bits per frame for a given data width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that tracks the bits left in a frame.
// is_one is registered so that it can drive the last output directly.
module piso_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          is_one
);

  logic [CW-1:0] cnt_nxt;

  // A load takes priority over a decrement on the same edge.
  always_comb begin
    cnt_nxt = count;
    if (load) begin
      cnt_nxt = load_val;
    end else if (dec && (count != '0)) begin
      cnt_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      is_one <= 1'b0;
    end else begin
      count  <= cnt_nxt;
      is_one <= (cnt_nxt == CW'(1));
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load and per-word bit order.
// Build option: PISO_PARITY_EN adds a trailing even-parity bit (state PARITY).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             lsb_first,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  // Extra counter bit keeps WIDTH+1 representable when parity is enabled.
  localparam int            CW            = CNT_W + PARITY_BITS;
  localparam logic [CW-1:0] LEN           = CW'(frame_len(WIDTH));
  localparam logic [CW-1:0] DATA_LAST_CNT = CW'(1 + PARITY_BITS);

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             lsb_r;
`ifdef PISO_PARITY_EN
  logic             par_r;
`endif
  logic             load_acc;
  logic             xfer;
  logic             data_last;
  logic [CW-1:0]    count;

  assign load_ready = rst_n && ((state == IDLE) || (last && shift_en));
  assign load_acc   = load_valid && load_ready;
  assign xfer       = q_valid && shift_en;
  assign data_last  = (count == DATA_LAST_CNT);

  piso_bit_counter #(
    .CW(CW)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_acc),
    .load_val(LEN),
    .dec     (xfer),
    .count   (count),
    .is_one  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_acc) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (xfer && data_last) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = load_acc ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (xfer) state_nxt = load_acc ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Word storage carries no reset; q_valid gates everything it feeds.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      sreg  <= din;
      lsb_r <= lsb_first;
`ifdef PISO_PARITY_EN
      par_r <= ^din;
`endif
    end else if (xfer) begin
      sreg <= lsb_r ? (sreg >> 1) : (sreg << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      q_valid <= (state_nxt != IDLE);
      busy    <= (state_nxt != IDLE);
      if (load_acc) begin
        q <= lsb_first ? din[0] : din[WIDTH-1];
      end else if (xfer) begin
        if (state_nxt == SHIFT) begin
          q <= lsb_r ? sreg[1] : sreg[WIDTH-2];
`ifdef PISO_PARITY_EN
        end else if (state_nxt == PARITY) begin
          q <= par_r;
`endif
        end else begin
          q <= 1'b0;
        end
      end
    end
  end

endmodule
